link_upstream_tx: RTL and testbench
===================================

# link_upstream_tx

Transmit end of the off-chip DDR link: accepts WIDTH-bit words from the core on a valid/ready handshake, buffers them, and serializes each word into CHANNEL_WIDTH-bit beats on the io channel that feeds the downstream receiver. Flow control is credit-based: each packet sent consumes one credit, and each edge of the receiver's token line returns one. The block runs in a single clock domain and sits between the core-side producer and the io pad/DDR output stage.

## Interface
- WIDTH, 32: core word width; must be a multiple of CHANNEL_WIDTH.
- CHANNEL_WIDTH, 8: io beat width.
- FIFO_DEPTH, 4: input buffer entries (power of two, ≥2).
- CREDITS, 16: receiver buffer capacity in packets; initial credit count.
- clk  in  1  clock; reset rst, synchronous, active-high; clock clk.
- rst  in  1  synchronous active-high reset.
- core_data_i  in  WIDTH  word to send.
- core_valid_i  in  1  core word valid.
- core_ready_o  out  1  buffer can accept; transfer on valid&&ready.
- io_data_o  out  CHANNEL_WIDTH  current beat, registered.
- io_valid_o  out  1  beat valid, registered.
- io_token_i  in  1  token line from receiver, already synchronous to clk; each edge (rise or fall) = one credit.
- credit_cnt_o  out  $clog2(CREDITS+1)  current credits.
- credit_err_o  out  1  sticky: token edge arrived with credits already at CREDITS.

## Operation
- NUM_BEATS = WIDTH/CHANNEL_WIDTH; beats sent LSB slice first.
- Input FIFO: core_ready_o = !full; write on core_valid_i && core_ready_o.
- FSM states IDLE, SEND.
  - IDLE: if FIFO non-empty and credits > 0 → pop head into shift register, credits −1, beat_cnt ← 0, go SEND.
  - SEND: drive beat beat_cnt; beat_cnt +1 each cycle. On last beat: if FIFO non-empty and effective credits > 0 → load next word (no bubble), stay SEND; else → IDLE.
- Effective credits = credit_cnt + (token edge this cycle); a same-cycle return makes a zero count usable.
- Token edge = io_token_i != tok_r; tok_r registered each cycle.
- Credit counter: consume and return in same cycle → unchanged. Return at CREDITS → counter holds, credit_err_o set until rst.
- Credits = 0 with data pending: FSM waits in IDLE, io_valid_o = 0, FIFO fills, core_ready_o drops when full.
- io_data_o holds last value when io_valid_o = 0 (no required content).

## Timing
- Reset values: io_valid_o 0, io_data_o 0, core_ready_o 0 while rst high then 1, credit_cnt_o CREDITS, credit_err_o 0, tok_r 0, FSM IDLE, FIFO empty.
- Accept in cycle t (FIFO empty, credits available) → FSM loads in t+1 → first beat on io_data_o/io_valid_o in t+2; last beat in t+1+NUM_BEATS.
- Back-to-back packets: io_valid_o continuously high, NUM_BEATS beats per packet.
- Token edge in cycle t → credit_cnt_o updated in t+1; can also launch a packet in t.
- FIFO full and pop same cycle: write accepted only if not full at start of cycle (ready is !full, no pass-through).
- rst mid-packet: packet truncated, io_valid_o 0 the next cycle, FIFO flushed, credits restored to CREDITS; io_token_i must be low during rst.

## Configuration
- LINK_UPSTREAM_TX_PARITY_EN defined: extra output io_parity_o (1 bit, registered alongside io_data_o) = even parity (XOR) of io_data_o; reset 0.
- Undefined: port absent, no parity logic; all other behaviour identical.

## Structure
- Package link_pkg: default widths, CREDITS, tx FSM state enum (IDLE, SEND), credit-counter width function.
- One sub-module: link_tx_fifo (synchronous FIFO, FIFO_DEPTH × WIDTH, full/empty flags, wrap-around pointers with extra MSB).
- Top holds FSM, shift register, beat counter, credit counter, token edge detect.

## Test plan
- Single word 0xDDCCBBAA after reset → io_valid_o high cycles t+2..t+5, io_data_o AA, BB, CC, DD; credit_cnt_o 16 → 15.
- 20 words back-to-back, no tokens → exactly 16 packets (64 contiguous beats), then io_valid_o 0; FIFO fills, core_ready_o 0; credit_cnt_o 0.
- From the stalled state, toggle io_token_i once → one more packet of 4 beats within 2 cycles; credit_cnt_o stays 0.
- Token edge in the same cycle as a packet launch at credits = 5 → credit_cnt_o stays 5.
- Token edge at credits = 16 → credit_cnt_o stays 16, credit_err_o 1 and sticky.
- rst asserted after beat 2 of a packet → io_valid_o 0 next cycle, core_ready_o 1 after release, credit_cnt_o 16; with LINK_UPSTREAM_TX_PARITY_EN, beat 0x07 → io_parity_o 1.

Source files
------------

// File: rtl/link_pkg.sv
// rtl/link_pkg.sv - shared defaults, tx FSM state type and credit-width helper for the upstream link
package link_pkg;

  localparam int LINK_WIDTH         = 32;
  localparam int LINK_CHANNEL_WIDTH = 8;
  localparam int LINK_FIFO_DEPTH    = 4;
  localparam int LINK_CREDITS       = 16;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } tx_state_e;

  // Counter must hold every value 0..credits inclusive.
  function automatic int credit_cnt_w(input int credits);
    return $clog2(credits + 1);
  endfunction

endpackage

// File: rtl/link_tx_fifo.sv
// rtl/link_tx_fifo.sv - synchronous word buffer between the core producer and the tx serializer
//
// Ports:
//   clk, rst          clock, synchronous active-high reset (flushes the buffer)
//   wr_en_i/wr_data_i write request and word; ignored while full
//   rd_en_i           pop the head word; ignored while empty
//   rd_data_o         head word (valid while !empty_o)
//   full_o, empty_o   occupancy flags
module link_tx_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  // Extra MSB distinguishes full from empty when the index bits match.
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;

  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en_i && !full_o) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (rd_en_i && !empty_o) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  // Storage needs no reset; the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (!rst && wr_en_i && !full_o) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end
  end

endmodule

// File: rtl/link_upstream_tx.sv
// rtl/link_upstream_tx.sv - credit-flow-controlled serializer driving the off-chip DDR link
//
// Buffers core words, then sends each as WIDTH/CHANNEL_WIDTH beats, LSB slice first.
// One credit is consumed per packet; every edge on io_token_i returns one.
// Optional build macro: LINK_UPSTREAM_TX_PARITY_EN adds io_parity_o (even parity of io_data_o).
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   core_data_i/core_valid_i   word from the core
//   core_ready_o               buffer can accept (transfer on valid && ready)
//   io_data_o/io_valid_o       registered beat to the pad stage
//   io_parity_o                (parity build only) registered XOR of io_data_o
//   io_token_i                 credit-return line, already synchronous to clk
//   credit_cnt_o               credits currently held
//   credit_err_o               sticky: a credit came back while already at CREDITS
module link_upstream_tx
  import link_pkg::*;
#(
  parameter int WIDTH         = LINK_WIDTH,
  parameter int CHANNEL_WIDTH = LINK_CHANNEL_WIDTH,
  parameter int FIFO_DEPTH    = LINK_FIFO_DEPTH,
  parameter int CREDITS       = LINK_CREDITS
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [WIDTH-1:0]                      core_data_i,
  input  logic                                  core_valid_i,
  output logic                                  core_ready_o,
  output logic [CHANNEL_WIDTH-1:0]              io_data_o,
  output logic                                  io_valid_o,
`ifdef LINK_UPSTREAM_TX_PARITY_EN
  output logic                                  io_parity_o,
`endif
  input  logic                                  io_token_i,
  output logic [credit_cnt_w(CREDITS)-1:0]      credit_cnt_o,
  output logic                                  credit_err_o
);

  localparam int NUM_BEATS = WIDTH / CHANNEL_WIDTH;
  localparam int BEAT_W    = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam int CNT_W     = credit_cnt_w(CREDITS);
  localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(NUM_BEATS - 1);
  localparam logic [CNT_W-1:0]  CREDIT_MAX = CNT_W'(CREDITS);

  tx_state_e                state_q;
  logic [WIDTH-1:0]         shift_q;
  logic [BEAT_W-1:0]        beat_cnt_q;
  logic [CNT_W-1:0]         credit_q;
  logic                     tok_q;
  logic                     credit_err_q;
  logic                     io_valid_q;
  logic [CHANNEL_WIDTH-1:0] io_data_q;
`ifdef LINK_UPSTREAM_TX_PARITY_EN
  logic                     io_parity_q;
`endif

  logic [WIDTH-1:0]         fifo_rd_data;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     fifo_wr;
  logic                     tok_edge;
  logic                     credit_ok;
  logic                     last_beat;
  logic                     launch;
  logic [CHANNEL_WIDTH-1:0] beat_d;

  // Ready is held low during reset so nothing is accepted into a flushing buffer.
  assign core_ready_o = !fifo_full && !rst;
  assign fifo_wr      = core_valid_i && core_ready_o;

  link_tx_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (fifo_wr),
    .wr_data_i (core_data_i),
    .rd_en_i   (launch),
    .rd_data_o (fifo_rd_data),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  // A token returned this cycle counts immediately, so a zero count can still launch.
  assign tok_edge  = io_token_i ^ tok_q;
  assign credit_ok = (credit_q != '0) || tok_edge;
  assign last_beat = (state_q == SEND) && (beat_cnt_q == LAST_BEAT);
  // Launch from IDLE, or chain straight off the last beat so packets run without a gap.
  assign launch    = !fifo_empty && credit_ok && ((state_q == IDLE) || last_beat);
  // shift_q keeps the not-yet-sent slices with the next one at the LSB end.
  assign beat_d    = launch ? fifo_rd_data[CHANNEL_WIDTH-1:0] : shift_q[CHANNEL_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      beat_cnt_q   <= '0;
      credit_q     <= CREDIT_MAX;
      tok_q        <= 1'b0;
      credit_err_q <= 1'b0;
      io_valid_q   <= 1'b0;
      io_data_q    <= '0;
`ifdef LINK_UPSTREAM_TX_PARITY_EN
      io_parity_q  <= 1'b0;
`endif
    end else begin
      tok_q <= io_token_i;

      // Consume and return in the same cycle cancel out.
      if (launch && !tok_edge) begin
        credit_q <= credit_q - 1'b1;
      end else if (!launch && tok_edge) begin
        if (credit_q == CREDIT_MAX) begin
          credit_err_q <= 1'b1;
        end else begin
          credit_q <= credit_q + 1'b1;
        end
      end

      if (launch) begin
        state_q    <= SEND;
        shift_q    <= fifo_rd_data >> CHANNEL_WIDTH;
        beat_cnt_q <= '0;
        io_valid_q <= 1'b1;
        io_data_q  <= beat_d;
`ifdef LINK_UPSTREAM_TX_PARITY_EN
        io_parity_q <= ^beat_d;
`endif
      end else if ((state_q == SEND) && !last_beat) begin
        shift_q    <= shift_q >> CHANNEL_WIDTH;
        beat_cnt_q <= beat_cnt_q + 1'b1;
        io_valid_q <= 1'b1;
        io_data_q  <= beat_d;
`ifdef LINK_UPSTREAM_TX_PARITY_EN
        io_parity_q <= ^beat_d;
`endif
      end else begin
        // io_data_o simply holds its last beat while idle.
        state_q    <= IDLE;
        io_valid_q <= 1'b0;
      end
    end
  end

  assign io_data_o    = io_data_q;
  assign io_valid_o   = io_valid_q;
  assign credit_cnt_o = credit_q;
  assign credit_err_o = credit_err_q;
`ifdef LINK_UPSTREAM_TX_PARITY_EN
  assign io_parity_o  = io_parity_q;
`endif

endmodule

// File: tb/tb_link_upstream_tx.sv
// tb/tb_link_upstream_tx.sv - self-checking bench for link_upstream_tx
`timescale 1ns/1ps
module tb_link_upstream_tx;

  localparam int NB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] core_data_i = '0;
  logic        core_valid_i = 1'b0;
  logic        core_ready_o;
  logic [7:0]  io_data_o;
  logic        io_valid_o;
`ifdef LINK_UPSTREAM_TX_PARITY_EN
  logic        io_parity_o;
`endif
  logic        io_token_i = 1'b0;
  logic [4:0]  credit_cnt_o;
  logic        credit_err_o;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb[$];
  logic [7:0] exp_b;
  int run_len = 0;
  int last_run = 0;
  int beat_total = 0;

  link_upstream_tx dut (
    .clk          (clk),
    .rst          (rst),
    .core_data_i  (core_data_i),
    .core_valid_i (core_valid_i),
    .core_ready_o (core_ready_o),
    .io_data_o    (io_data_o),
    .io_valid_o   (io_valid_o),
`ifdef LINK_UPSTREAM_TX_PARITY_EN
    .io_parity_o  (io_parity_o),
`endif
    .io_token_i   (io_token_i),
    .credit_cnt_o (credit_cnt_o),
    .credit_err_o (credit_err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard: every valid beat must match the next expected slice.
  always @(negedge clk) begin
    if (rst) begin
      run_len = 0;
    end else if (io_valid_o) begin
      run_len++;
      beat_total++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL beat_unexpected: got %02h, expected no beat", io_data_o);
      end else begin
        exp_b = sb.pop_front();
        if (io_data_o !== exp_b) begin
          errors++;
          $display("FAIL beat_data: got %02h, expected %02h", io_data_o, exp_b);
        end
      end
`ifdef LINK_UPSTREAM_TX_PARITY_EN
      checks++;
      if (io_parity_o !== ^io_data_o) begin
        errors++;
        $display("FAIL beat_parity: got %0b, expected %0b", io_parity_o, ^io_data_o);
      end
`endif
    end else begin
      if (run_len != 0) last_run = run_len;
      run_len = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int i = 0; i < NB; i++) sb.push_back(w[i*8 +: 8]);
  endtask

  task automatic send_word(input logic [31:0] w);
    int n;
    n = 0;
    core_data_i  = w;
    core_valid_i = 1'b1;
    while (!core_ready_o && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (core_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL send_timeout: ready=%0b after %0d cycles, expected 1", core_ready_o, n);
    end else begin
      push_word(w);
    end
    tick();
    core_valid_i = 1'b0;
  endtask

  task automatic do_reset();
    io_token_i   = 1'b0;
    core_valid_i = 1'b0;
    rst = 1'b1;
    repeat (2) tick();
    sb.delete();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    repeat (2) tick();
    checks++; if (io_valid_o !== 1'b0) begin errors++; $display("FAIL rst_io_valid: got %0b, expected 0", io_valid_o); end
    checks++; if (io_data_o !== 8'h00) begin errors++; $display("FAIL rst_io_data: got %02h, expected 00", io_data_o); end
    checks++; if (core_ready_o !== 1'b0) begin errors++; $display("FAIL rst_ready_in_rst: got %0b, expected 0", core_ready_o); end
    checks++; if (credit_cnt_o !== 5'd16) begin errors++; $display("FAIL rst_credit: got %0d, expected 16", credit_cnt_o); end
    checks++; if (credit_err_o !== 1'b0) begin errors++; $display("FAIL rst_err: got %0b, expected 0", credit_err_o); end
    rst = 1'b0;
    tick();
    checks++; if (core_ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready_after: got %0b, expected 1", core_ready_o); end
  endtask

  task automatic test_single();
    core_data_i  = 32'hDDCCBBAA;
    core_valid_i = 1'b1;
    push_word(32'hDDCCBBAA);
    tick();
    core_valid_i = 1'b0;
    checks++; if (io_valid_o !== 1'b0) begin errors++; $display("FAIL single_t1_valid: got %0b, expected 0", io_valid_o); end
    for (int i = 0; i < NB; i++) begin
      tick();
      checks++; if (io_valid_o !== 1'b1) begin errors++; $display("FAIL single_beat%0d_valid: got %0b, expected 1", i, io_valid_o); end
    end
    tick();
    checks++; if (io_valid_o !== 1'b0) begin errors++; $display("FAIL single_end_valid: got %0b, expected 0", io_valid_o); end
    checks++; if (credit_cnt_o !== 5'd15) begin errors++; $display("FAIL single_credit: got %0d, expected 15", credit_cnt_o); end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL single_sb_left: got %0d, expected 0", sb.size()); end
  endtask

  task automatic test_back_to_back();
    int start;
    do_reset();
    start = beat_total;
    for (int i = 0; i < 20; i++) send_word($urandom);
    repeat (80) tick();
    checks++; if (beat_total - start != 64) begin errors++; $display("FAIL b2b_beats: got %0d, expected 64", beat_total - start); end
    checks++; if (last_run != 64) begin errors++; $display("FAIL b2b_run: got %0d, expected 64", last_run); end
    checks++; if (io_valid_o !== 1'b0) begin errors++; $display("FAIL b2b_stall_valid: got %0b, expected 0", io_valid_o); end
    checks++; if (core_ready_o !== 1'b0) begin errors++; $display("FAIL b2b_ready: got %0b, expected 0", core_ready_o); end
    checks++; if (credit_cnt_o !== 5'd0) begin errors++; $display("FAIL b2b_credit: got %0d, expected 0", credit_cnt_o); end
  endtask

  task automatic test_token_stall();
    int start;
    int n;
    start = beat_total;
    io_token_i = 1'b1;
    tick();
    n = 1;
    while (!io_valid_o && n < 2) begin
      tick();
      n++;
    end
    checks++; if (io_valid_o !== 1'b1) begin errors++; $display("FAIL tok_launch: valid=%0b after %0d cycles, expected 1", io_valid_o, n); end
    repeat (8) tick();
    checks++; if (beat_total - start != 4) begin errors++; $display("FAIL tok_beats: got %0d, expected 4", beat_total - start); end
    checks++; if (last_run != 4) begin errors++; $display("FAIL tok_run: got %0d, expected 4", last_run); end
    checks++; if (credit_cnt_o !== 5'd0) begin errors++; $display("FAIL tok_credit: got %0d, expected 0", credit_cnt_o); end
  endtask

  task automatic test_same_cycle_credit();
    do_reset();
    for (int i = 0; i < 11; i++) send_word($urandom);
    repeat (60) tick();
    checks++; if (credit_cnt_o !== 5'd5) begin errors++; $display("FAIL same_pre_credit: got %0d, expected 5", credit_cnt_o); end
    core_data_i  = 32'h5A5A1234;
    core_valid_i = 1'b1;
    push_word(32'h5A5A1234);
    tick();
    core_valid_i = 1'b0;
    io_token_i   = 1'b1;
    tick();
    checks++; if (io_valid_o !== 1'b1) begin errors++; $display("FAIL same_launch: got %0b, expected 1", io_valid_o); end
    checks++; if (credit_cnt_o !== 5'd5) begin errors++; $display("FAIL same_credit: got %0d, expected 5", credit_cnt_o); end
    repeat (6) tick();
    io_token_i = 1'b0;
    tick();
    checks++; if (credit_cnt_o !== 5'd6) begin errors++; $display("FAIL same_return: got %0d, expected 6", credit_cnt_o); end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL same_sb_left: got %0d, expected 0", sb.size()); end
  endtask

  task automatic test_credit_err();
    do_reset();
    checks++; if (credit_err_o !== 1'b0) begin errors++; $display("FAIL err_pre: got %0b, expected 0", credit_err_o); end
    io_token_i = 1'b1;
    tick();
    checks++; if (credit_cnt_o !== 5'd16) begin errors++; $display("FAIL err_credit: got %0d, expected 16", credit_cnt_o); end
    checks++; if (credit_err_o !== 1'b1) begin errors++; $display("FAIL err_set: got %0b, expected 1", credit_err_o); end
    send_word(32'h0BADF00D);
    repeat (8) tick();
    checks++; if (credit_err_o !== 1'b1) begin errors++; $display("FAIL err_sticky: got %0b, expected 1", credit_err_o); end
    checks++; if (credit_cnt_o !== 5'd15) begin errors++; $display("FAIL err_after_send: got %0d, expected 15", credit_cnt_o); end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    send_word(32'h44332207);
    send_word(32'h88776655);
    checks++; if (io_valid_o !== 1'b1 || io_data_o !== 8'h07) begin errors++; $display("FAIL mid_first_beat: got v=%0b d=%02h, expected v=1 d=07", io_valid_o, io_data_o); end
`ifdef LINK_UPSTREAM_TX_PARITY_EN
    checks++; if (io_parity_o !== 1'b1) begin errors++; $display("FAIL mid_parity: got %0b, expected 1", io_parity_o); end
`endif
    send_word(32'hCCBBAA99);
    @(negedge clk);
    #1;
    rst = 1'b1;
    tick();
    checks++; if (io_valid_o !== 1'b0) begin errors++; $display("FAIL mid_valid: got %0b, expected 0", io_valid_o); end
    checks++; if (core_ready_o !== 1'b0) begin errors++; $display("FAIL mid_ready_rst: got %0b, expected 0", core_ready_o); end
    sb.delete();
    tick();
    rst = 1'b0;
    #1;
    checks++; if (core_ready_o !== 1'b1) begin errors++; $display("FAIL mid_ready_after: got %0b, expected 1", core_ready_o); end
    checks++; if (credit_cnt_o !== 5'd16) begin errors++; $display("FAIL mid_credit: got %0d, expected 16", credit_cnt_o); end
    tick();
    send_word(32'hF00DCAFE);
    repeat (8) tick();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL mid_sb_left: got %0d, expected 0", sb.size()); end
    checks++; if (last_run != 4) begin errors++; $display("FAIL mid_resume_run: got %0d, expected 4", last_run); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_token_stall();
    test_same_cycle_credit();
    test_credit_err();
    test_reset_mid_packet();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
